mux_scan_ctl: RTL and testbench

MUX_SCAN_CTL -- requirements
Module: mux_scan_ctl

---
 rtl/mux_scan_ctl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctl.sv
// Scan controller for an external 8:1 mux: steps the select through all eight channels,
// waits SETTLE cycles per channel, samples W and publishes the byte with a valid/ack handshake.
module mux_scan_ctl #(
    parameter int unsigned SETTLE = 2  // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_w,
    input  logic       ack,
    output logic [2:0] sel,
    output logic       strobe_n,
    output logic       busy,
    output logic [7:0] data,
    output logic       valid,
    output logic       changed
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic       strobe_n_q, strobe_n_d;
    logic       busy_q, busy_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       changed_q, changed_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        strobe_n_d = strobe_n_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        valid_d    = valid_q;
        changed_d  = changed_q;

        case (state_q)
            StIdle: begin
                if (start || cont) begin
                    state_d    = StSettle;
                    sel_d      = 3'd0;
                    strobe_n_d = 1'b0;
                    cnt_d      = CntLoad;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSample: begin
                shadow_d[sel_q] = mux_w;
                if (sel_q != 3'd7) begin
                    sel_d   = sel_q + 3'd1;
                    cnt_d   = CntLoad;
                    state_d = StSettle;
                end else begin
                    // Publish includes the bit captured on this very edge.
                    state_d    = StDone;
                    data_d     = shadow_d;
                    valid_d    = 1'b1;
                    changed_d  = (shadow_d != data_q);
                    strobe_n_d = 1'b1;
                    sel_d      = 3'd0;
                end
            end
            StDone: begin
                if (ack) begin
                    valid_d   = 1'b0;
                    changed_d = 1'b0;
                    if (cont) begin
                        state_d    = StSettle;
                        sel_d      = 3'd0;
                        strobe_n_d = 1'b0;
                        cnt_d      = CntLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            sel_q      <= 3'd0;
            strobe_n_q <= 1'b1;
            busy_q     <= 1'b0;
            shadow_q   <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            strobe_n_q <= strobe_n_d;
            busy_q     <= busy_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
        end
    end

    assign sel      = sel_q;
    assign strobe_n = strobe_n_q;
    assign busy     = busy_q;
    assign data     = data_q;
    assign valid    = valid_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_mux_scan_ctl.sv
// Bench for mux_scan_ctl: three instances (SETTLE = 2, 1, 15) checked against a timing and
// data model derived from channel dwell arithmetic and the previous published byte.
module tb_mux_scan_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_v[3];
    logic       cont_v[3];
    logic       ack_v[3];
    logic       mux_w_v[3];
    logic       strobe_n_v[3];
    logic       busy_v[3];
    logic       valid_v[3];
    logic       changed_v[3];
    logic [2:0] sel_v[3];
    logic [7:0] data_v[3];
    logic [7:0] pat_v[3];

    // Model state: last published byte and its changed flag per instance.
    logic [7:0] prev_v[3];
    logic       chg_v[3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // External mux: W follows the selected input while enabled, low when disabled.
    assign mux_w_v[0] = strobe_n_v[0] ? 1'b0 : pat_v[0][sel_v[0]];
    assign mux_w_v[1] = strobe_n_v[1] ? 1'b0 : pat_v[1][sel_v[1]];
    assign mux_w_v[2] = strobe_n_v[2] ? 1'b0 : pat_v[2][sel_v[2]];

    mux_scan_ctl #(.SETTLE(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .cont(cont_v[0]),
        .mux_w(mux_w_v[0]), .ack(ack_v[0]), .sel(sel_v[0]), .strobe_n(strobe_n_v[0]),
        .busy(busy_v[0]), .data(data_v[0]), .valid(valid_v[0]), .changed(changed_v[0])
    );

    mux_scan_ctl #(.SETTLE(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .cont(cont_v[1]),
        .mux_w(mux_w_v[1]), .ack(ack_v[1]), .sel(sel_v[1]), .strobe_n(strobe_n_v[1]),
        .busy(busy_v[1]), .data(data_v[1]), .valid(valid_v[1]), .changed(changed_v[1])
    );

    mux_scan_ctl #(.SETTLE(15)) u_s15 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .cont(cont_v[2]),
        .mux_w(mux_w_v[2]), .ack(ack_v[2]), .sel(sel_v[2]), .strobe_n(strobe_n_v[2]),
        .busy(busy_v[2]), .data(data_v[2]), .valid(valid_v[2]), .changed(changed_v[2])
    );

    function automatic int unsigned settle_of(input int i);
        if (i == 0) return 2;
        if (i == 1) return 1;
        return 15;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int i, input string tag);
        check_eq({tag, ".sel"}, 32'(sel_v[i]), 32'd0);
        check_eq({tag, ".strobe_n"}, 32'(strobe_n_v[i]), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy_v[i]), 32'd0);
        check_eq({tag, ".valid"}, 32'(valid_v[i]), 32'd0);
        check_eq({tag, ".changed"}, 32'(changed_v[i]), 32'd0);
        check_eq({tag, ".data"}, 32'(data_v[i]), 32'(prev_v[i]));
    endtask

    // Drive a request and take the start edge.
    task automatic kick(input int i, input bit use_start, input bit use_cont);
        start_v[i] = use_start;
        cont_v[i]  = use_cont;
        tick();
        start_v[i] = 1'b0;
    endtask

    // Called just after the start edge; follows the scan through to the publish edge.
    task automatic scan_body(input int i, input bit inject);
        int unsigned s;
        int unsigned dwell;
        int unsigned last;
        s     = settle_of(i);
        dwell = s + 1;
        last  = 8 * dwell;
        for (int unsigned e = 0; e <= last; e++) begin
            if (e < last) begin
                check_eq("scan.sel", 32'(sel_v[i]), e / dwell);
                check_eq("scan.strobe_n", 32'(strobe_n_v[i]), 32'd0);
                check_eq("scan.busy", 32'(busy_v[i]), 32'd1);
                check_eq("scan.valid_low", 32'(valid_v[i]), 32'd0);
                start_v[i] = inject && (e == 3 * dwell);
                ack_v[i]   = inject && (e == 4 * dwell + s);
                tick();
            end else begin
                chg_v[i] = (pat_v[i] != prev_v[i]);
                check_eq("done.valid", 32'(valid_v[i]), 32'd1);
                check_eq("done.data", 32'(data_v[i]), 32'(pat_v[i]));
                check_eq("done.changed", 32'(changed_v[i]), 32'(chg_v[i]));
                check_eq("done.strobe_n", 32'(strobe_n_v[i]), 32'd1);
                check_eq("done.sel", 32'(sel_v[i]), 32'd0);
                check_eq("done.busy", 32'(busy_v[i]), 32'd1);
                prev_v[i] = pat_v[i];
            end
        end
        start_v[i] = 1'b0;
        ack_v[i]   = 1'b0;
    endtask

    // Hold DONE for some cycles without ack, then ack; keep_cont chains the next scan.
    task automatic finish_ack(input int i, input int unsigned hold, input bit keep_cont,
                              input logic [7:0] next_pat);
        for (int unsigned k = 0; k < hold; k++) begin
            cont_v[i] = 1'($urandom_range(0, 1));
            tick();
            check_eq("hold.valid", 32'(valid_v[i]), 32'd1);
            check_eq("hold.data", 32'(data_v[i]), 32'(prev_v[i]));
            check_eq("hold.changed", 32'(changed_v[i]), 32'(chg_v[i]));
            check_eq("hold.busy", 32'(busy_v[i]), 32'd1);
        end
        pat_v[i]  = next_pat;
        cont_v[i] = keep_cont;
        ack_v[i]  = 1'b1;
        tick();
        ack_v[i]  = 1'b0;
        check_eq("ack.valid", 32'(valid_v[i]), 32'd0);
        check_eq("ack.changed", 32'(changed_v[i]), 32'd0);
        check_eq("ack.data", 32'(data_v[i]), 32'(prev_v[i]));
        check_eq("ack.sel", 32'(sel_v[i]), 32'd0);
        check_eq("ack.busy", 32'(busy_v[i]), 32'(keep_cont));
        check_eq("ack.strobe_n", 32'(strobe_n_v[i]), 32'(!keep_cont));
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            cont_v[i]  = 1'b0;
            ack_v[i]   = 1'b0;
            pat_v[i]   = 8'h00;
            prev_v[i]  = 8'h00;
            chg_v[i]   = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) check_idle(i, "post_reset");

        // Single start with 0xA5, first scan compares against 0x00.
        pat_v[0] = 8'hA5;
        kick(0, 1'b1, 1'b0);
        scan_body(0, 1'b0);
        finish_ack(0, 3, 1'b0, 8'hA5);
        check_idle(0, "idle_after_a5");

        // Same pattern again: changed must stay low; hold 10 cycles without ack.
        kick(0, 1'b1, 1'b0);
        scan_body(0, 1'b0);
        finish_ack(0, 10, 1'b0, 8'hA5);

        // Continuous mode, pattern switched between scans, no IDLE gap.
        pat_v[0] = 8'h0F;
        kick(0, 1'b0, 1'b1);
        scan_body(0, 1'b0);
        finish_ack(0, 2, 1'b1, 8'hF0);
        scan_body(0, 1'b0);
        finish_ack(0, 1, 1'b0, 8'h5A);

        // Start during SETTLE and ack during SAMPLE are ignored.
        kick(0, 1'b1, 1'b0);
        scan_body(0, 1'b1);
        finish_ack(0, 2, 1'b0, 8'h5A);

        // Start and cont together, cont dropped mid-scan: one scan, then IDLE.
        pat_v[0] = 8'h3C;
        kick(0, 1'b1, 1'b1);
        cont_v[0] = 1'b0;
        scan_body(0, 1'b0);
        finish_ack(0, 0, 1'b0, 8'h3C);

        // Ack in IDLE does nothing.
        ack_v[0] = 1'b1;
        tick();
        ack_v[0] = 1'b0;
        tick();
        check_idle(0, "ack_in_idle");

        // Asynchronous reset at sel=5 mid-scan.
        pat_v[0] = 8'hC3;
        kick(0, 1'b1, 1'b0);
        repeat (15) tick();
        check_eq("pre_reset.sel", 32'(sel_v[0]), 32'd5);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            prev_v[i] = 8'h00;
            check_idle(i, "async_reset");
        end
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            check_idle(0, "no_autostart");
        end
        pat_v[0] = 8'($urandom);
        kick(0, 1'b1, 1'b0);
        scan_body(0, 1'b0);
        finish_ack(0, 1, 1'b0, 8'h00);

        // Settle extremes on the other instances.
        for (int i = 1; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                pat_v[i] = 8'($urandom);
                kick(i, 1'b1, 1'b0);
                scan_body(i, 1'b0);
                finish_ack(i, $urandom_range(0, 3), 1'b0, 8'h00);
            end
        end

        // Randomized scans, modes and chain lengths.
        for (int it = 0; it < 6; it++) begin
            int unsigned m;
            int unsigned nchain;
            m        = $urandom_range(0, 2);
            nchain   = $urandom_range(1, 3);
            pat_v[0] = (it == 2) ? prev_v[0] : 8'($urandom);
            kick(0, m != 1, m != 0);
            for (int unsigned k = 0; k < nchain; k++) begin
                scan_body(0, 1'($urandom_range(0, 1)));
                finish_ack(0, $urandom_range(0, 4), k + 1 < nchain,
                           ($urandom_range(0, 3) == 0) ? prev_v[0] : 8'($urandom));
            end
            tick();
            check_idle(0, "rand_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
